rv32i_fetch: RTL and testbench
==============================

# rv32i_fetch

Instruction-fetch stage and IF/ID pipeline register for the pipelined RV32I core. Maintains the PC, issues one instruction-memory request at a time over a valid/ready channel, and captures returned words into the IF/ID register. `ifid_instr` drives the decode stage and the immediate generator directly. Handles branch/jump redirects from EX, hazard-unit stalls, and a one-entry hold buffer for responses that arrive while IF/ID is stalled.

## Interface
- RESET_PC, 32'h0000_0000: PC fetched first after reset; bits [1:0] must be 0.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response word valid; one response per accepted request, in order, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  taken branch/jump from EX; flush.
- redirect_pc  in  32  new PC; bits [1:0] forced to 00 internally.
- stall  in  1  hazard unit: hold IF/ID contents.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_pc  out  32  PC of `ifid_instr`.
- ifid_pc_plus4  out  32  `ifid_pc + 4`, modulo 2^32.
- ifid_instr  out  32  instruction to decode/immgen.

## Operation
- Reset (async assert) sets:
  - pc = RESET_PC, state = REQ, hold empty.
  - ifid_valid = 0, ifid_pc = 0, ifid_pc_plus4 = 0, ifid_instr = 32'h0000_0013 (NOP).
  - imem_req_valid = 0.
- States:
  - REQ: `imem_req_valid = hold_empty && !redirect_valid`; `imem_req_addr = pc`. On valid && ready: `req_pc <= pc`, `pc <= pc + 4` (wraps at 2^32), go to WAIT.
  - WAIT: on imem_rsp_valid, deliver {req_pc, data} and go to REQ.
  - DROP: an in-flight request is stale. On imem_rsp_valid, discard the data and go to REQ.
- Redirect has highest priority. It does all of the following:
  - Sets `pc <= redirect_pc & ~3`.
  - Clears ifid_valid, loads NOP into ifid_instr, and empties hold. This happens even if stall is asserted.
  - In WAIT without a response: go to DROP.
  - In WAIT with a response in the same cycle: discard the response, go to REQ.
  - In DROP: stay in DROP.
  - In REQ: no request is issued that cycle (valid is gated); stay in REQ.
- Delivery into IF/ID when there is no redirect:
  - IF/ID can accept when `!stall || !ifid_valid`.
  - Source priority: hold first, then the current response.
  - If a response is delivered but IF/ID cannot accept, or hold is occupied, the response goes into hold.
  - Hold full blocks new requests.
- IF/ID not stalled and no source available: ifid_valid <= 0, ifid_instr <= NOP (bubble); pc fields unchanged.
- IF/ID stalled: all IF/ID outputs hold their values.
- Only one request is outstanding at a time, so the hold buffer never needs more than one entry.

## Timing
- Request accepted in cycle N; response earliest in N+1. With no stall, ifid_valid rises in the cycle after the response.
- Peak throughput: 1 instruction per 2 cycles with a 1-cycle memory.
- Redirect in cycle R: IF/ID is bubbled from R+1. The first request to redirect_pc is presented no earlier than R+1, or after the stale response drains.
- imem_req_addr is stable while imem_req_valid is high and ready is low. A redirect drops valid for that cycle instead of changing the address under a pending request.
- Stall released with hold full: hold enters IF/ID on the next edge; requests resume the same cycle hold empties.
- rst_n asserted mid-transaction: all state returns to reset values immediately. Any late response is not tracked, so the memory must be reset with the core.

## Test plan
- Reset release, RESET_PC=0, memory ready=1 with 1-cycle latency returning 0x00500093, 0x00A00113 -> requests at 0x0, 0x4; IF/ID shows pc 0x0 then 0x4, pc_plus4 0x4 then 0x8, ifid_valid alternates 1/0.
- Stall held 3 cycles while the response for 0x8 arrives -> IF/ID frozen on 0x4; 0x8 parked in hold; no request for 0xC until stall drops; 0x8 appears the cycle after release.
- Redirect to 0x100 while in WAIT for 0x10 -> ifid_valid=0 next cycle; response for 0x10 discarded; next request address 0x100; no instruction from 0x10 ever shows valid.
- Redirect in the same cycle as the response, plus stall=1 -> IF/ID flushed to NOP with ifid_valid=0 despite the stall; response dropped; next request 0x100 (redirect_pc 0x102 is forced to 0x100).
- PC wrap with RESET_PC=32'hFFFF_FFFC -> first fetch at 0xFFFFFFFC, ifid_pc_plus4 = 0x0, next request address 0x0.
- rst_n pulsed low mid-WAIT with ready held low -> outputs immediately return to reset values; after release, first request is at RESET_PC.

Source files
------------

// File: rtl/rv32i_fetch.sv
// RV32I instruction-fetch stage and IF/ID pipeline register.
// One outstanding imem request, EX redirects, hazard stalls and a one-entry response hold buffer.
module rv32i_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic [31:0] ifid_instr
);

    localparam logic [31:0] Nop = 32'h0000_0013;

    typedef enum logic [1:0] {StReq, StWait, StDrop} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;

    logic req_fire;
    logic rsp_fire;
    logic ifid_ready;

    // Gated by rst_n so the request drops the instant reset asserts.
    assign imem_req_valid = rst_n && (state_q == StReq) && !hold_valid_q && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fire       = imem_rsp_valid && (state_q == StWait);
    assign ifid_ready     = !stall || !ifid_valid_q;

    assign ifid_valid    = ifid_valid_q;
    assign ifid_pc       = ifid_pc_q;
    assign ifid_pc_plus4 = ifid_pc_plus4_q;
    assign ifid_instr    = ifid_instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StReq;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReq: begin
                if (!redirect_valid && req_fire) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (imem_rsp_valid) begin
                    state_d = StReq;
                end else if (redirect_valid) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (imem_rsp_valid) begin
                    state_d = StReq;
                end
            end
            default: state_d = StReq;
        endcase
    end

    always_comb begin
        pc_d            = pc_q;
        req_pc_d        = req_pc_q;
        hold_valid_d    = hold_valid_q;
        hold_pc_d       = hold_pc_q;
        hold_instr_d    = hold_instr_q;
        ifid_valid_d    = ifid_valid_q;
        ifid_pc_d       = ifid_pc_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        ifid_instr_d    = ifid_instr_q;

        if (redirect_valid) begin
            // Flush wins over stall; ifid pc fields are left as they were.
            pc_d         = redirect_pc & ~32'd3;
            hold_valid_d = 1'b0;
            ifid_valid_d = 1'b0;
            ifid_instr_d = Nop;
        end else begin
            if (req_fire) begin
                req_pc_d = pc_q;
                pc_d     = pc_q + 32'd4;
            end
            if (ifid_ready) begin
                if (hold_valid_q) begin
                    ifid_valid_d    = 1'b1;
                    ifid_pc_d       = hold_pc_q;
                    ifid_pc_plus4_d = hold_pc_q + 32'd4;
                    ifid_instr_d    = hold_instr_q;
                    hold_valid_d    = rsp_fire;
                    if (rsp_fire) begin
                        hold_pc_d    = req_pc_q;
                        hold_instr_d = imem_rsp_data;
                    end
                end else if (rsp_fire) begin
                    ifid_valid_d    = 1'b1;
                    ifid_pc_d       = req_pc_q;
                    ifid_pc_plus4_d = req_pc_q + 32'd4;
                    ifid_instr_d    = imem_rsp_data;
                end else begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = Nop;
                end
            end else if (rsp_fire) begin
                hold_valid_d = 1'b1;
                hold_pc_d    = req_pc_q;
                hold_instr_d = imem_rsp_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q            <= RESET_PC;
            req_pc_q        <= 32'd0;
            hold_valid_q    <= 1'b0;
            hold_pc_q       <= 32'd0;
            hold_instr_q    <= 32'd0;
            ifid_valid_q    <= 1'b0;
            ifid_pc_q       <= 32'd0;
            ifid_pc_plus4_q <= 32'd0;
            ifid_instr_q    <= Nop;
        end else begin
            pc_q            <= pc_d;
            req_pc_q        <= req_pc_d;
            hold_valid_q    <= hold_valid_d;
            hold_pc_q       <= hold_pc_d;
            hold_instr_q    <= hold_instr_d;
            ifid_valid_q    <= ifid_valid_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            ifid_instr_q    <= ifid_instr_d;
        end
    end

endmodule

// File: tb/tb_rv32i_fetch.sv
// Scoreboard bench for rv32i_fetch: expected requests and IF/ID entries are queued by the
// directed stimulus and popped by a negedge monitor.
module tb_rv32i_fetch;

    localparam logic [31:0] Nop   = 32'h0000_0013;
    localparam logic [31:0] I0    = 32'h0050_0093;
    localparam logic [31:0] I1    = 32'h00A0_0113;
    localparam logic [31:0] I2    = 32'h0030_8193;
    localparam logic [31:0] I3    = 32'h0041_82B3;
    localparam logic [31:0] I4    = 32'h0010_0193;
    localparam logic [31:0] I5    = 32'h0020_0213;
    localparam logic [31:0] Stale = 32'h0000_0073;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } ifid_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_ready, rsp_valid, redir_valid, stall;
    logic [31:0] rsp_data, redir_pc;

    logic        req_valid0, ifid_valid0;
    logic [31:0] req_addr0, ifid_pc0, ifid_pc4_0, ifid_instr0;
    logic        req_valid1, ifid_valid1;
    logic [31:0] req_addr1, ifid_pc1, ifid_pc4_1, ifid_instr1;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [31:0] req_q[$];
    ifid_t       ifid_q[$];
    logic        frozen = 1'b0;

    always #5 clk = ~clk;

    rv32i_fetch #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(req_valid0), .imem_req_ready(req_ready), .imem_req_addr(req_addr0),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .redirect_valid(redir_valid), .redirect_pc(redir_pc), .stall(stall),
        .ifid_valid(ifid_valid0), .ifid_pc(ifid_pc0), .ifid_pc_plus4(ifid_pc4_0),
        .ifid_instr(ifid_instr0)
    );

    rv32i_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(req_valid1), .imem_req_ready(req_ready), .imem_req_addr(req_addr1),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .redirect_valid(redir_valid), .redirect_pc(redir_pc), .stall(stall),
        .ifid_valid(ifid_valid1), .ifid_pc(ifid_pc1), .ifid_pc_plus4(ifid_pc4_1),
        .ifid_instr(ifid_instr1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_ifid(input logic [31:0] pc, input logic [31:0] instr);
        ifid_t e;
        e.pc    = pc;
        e.pc4   = pc + 32'd4;
        e.instr = instr;
        ifid_q.push_back(e);
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                         input logic stl, input logic redv, input logic [31:0] redpc);
        req_ready   = rdy;
        rsp_valid   = rv;
        rsp_data    = rd;
        stall       = stl;
        redir_valid = redv;
        redir_pc    = redpc;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: an IF/ID entry is new unless it was valid and stalled at the previous edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            frozen = 1'b0;
        end else begin
            if (req_valid0 && req_ready) begin
                if (req_q.size() == 0) begin
                    check("unexpected_req", req_addr0, 32'hxxxx_xxxx);
                end else begin
                    check("req_addr", req_addr0, req_q.pop_front());
                end
            end
            if (ifid_valid0 && !frozen) begin
                if (ifid_q.size() == 0) begin
                    check("unexpected_ifid", ifid_pc0, 32'hxxxx_xxxx);
                end else begin
                    ifid_t e;
                    e = ifid_q.pop_front();
                    check("ifid_pc", ifid_pc0, e.pc);
                    check("ifid_pc_plus4", ifid_pc4_0, e.pc4);
                    check("ifid_instr", ifid_instr0, e.instr);
                end
            end
            frozen = ifid_valid0 && stall;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        check("rst_req_valid", {31'd0, req_valid0}, 32'd0);
        check("rst_ifid_valid", {31'd0, ifid_valid0}, 32'd0);
        check("rst_ifid_instr", ifid_instr0, Nop);
        check("rst_ifid_pc", ifid_pc0, 32'd0);
        check("rst_ifid_pc4", ifid_pc4_0, 32'd0);

        // Basic 1-cycle memory flow
        rst_n = 1'b1;
        req_q.push_back(32'h0);        drive(1, 0, 0, 0, 0, 0);  step();
        exp_ifid(32'h0, I0);           drive(1, 1, I0, 0, 0, 0); step();
        req_q.push_back(32'h4);        drive(1, 0, 0, 0, 0, 0);  step();
        exp_ifid(32'h4, I1);           drive(1, 1, I1, 0, 0, 0);
        check("alt_bubble", {31'd0, ifid_valid0}, 32'd0);        step();

        // Stall while response for 0x8 arrives
        req_q.push_back(32'h8);        drive(1, 0, 0, 1, 0, 0);  step();
        exp_ifid(32'h8, I2);           drive(1, 1, I2, 1, 0, 0); step();
        drive(1, 0, 0, 1, 0, 0);
        check("hold_blocks_req", {31'd0, req_valid0}, 32'd0);
        check("frozen_pc", ifid_pc0, 32'h4);                     step();
        drive(1, 0, 0, 0, 0, 0);
        check("hold_blocks_req_rel", {31'd0, req_valid0}, 32'd0); step();
        req_q.push_back(32'hC);        drive(1, 0, 0, 0, 0, 0);  step();
        exp_ifid(32'hC, I3);           drive(1, 1, I3, 0, 0, 0); step();

        // Redirect while waiting for 0x10
        req_q.push_back(32'h10);       drive(1, 0, 0, 0, 0, 0);  step();
        drive(1, 0, 0, 0, 1, 32'h100);                           step();
        drive(1, 1, Stale, 0, 0, 0);
        check("redir_ifid_valid", {31'd0, ifid_valid0}, 32'd0);
        check("drop_no_req", {31'd0, req_valid0}, 32'd0);        step();
        req_q.push_back(32'h100);      drive(1, 0, 0, 0, 0, 0);  step();
        exp_ifid(32'h100, I4);         drive(1, 1, I4, 0, 0, 0); step();

        // Redirect with concurrent response and stall; 0x102 aligns to 0x100
        req_q.push_back(32'h104);      drive(1, 0, 0, 1, 0, 0);  step();
        drive(1, 1, I5, 1, 1, 32'h102);                          step();
        req_q.push_back(32'h100);      drive(1, 0, 0, 0, 0, 0);
        check("flush_stall_valid", {31'd0, ifid_valid0}, 32'd0);
        check("flush_stall_instr", ifid_instr0, Nop);
        check("redir_aligned_addr", req_addr0, 32'h100);         step();
        exp_ifid(32'h100, I4);         drive(1, 1, I4, 0, 0, 0); step();

        // Redirect in REQ gates the request
        drive(1, 0, 0, 0, 1, 32'h200);
        check("redir_req_gated", {31'd0, req_valid0}, 32'd0);    step();
        req_q.push_back(32'h200);      drive(1, 0, 0, 0, 0, 0);  step();

        // Async reset mid-WAIT with ready low
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_valid", {31'd0, req_valid0}, 32'd0);
        check("mid_rst_ifid_valid", {31'd0, ifid_valid0}, 32'd0);
        check("mid_rst_ifid_pc", ifid_pc0, 32'd0);
        check("mid_rst_ifid_pc4", ifid_pc4_0, 32'd0);
        check("mid_rst_ifid_instr", ifid_instr0, Nop);
        step();
        step();

        // Release; dut1 exercises PC wrap
        rst_n = 1'b1;
        req_q.push_back(32'h0);        drive(1, 0, 0, 0, 0, 0);
        check("wrap_req_valid", {31'd0, req_valid1}, 32'd1);
        check("wrap_req_addr", req_addr1, 32'hFFFF_FFFC);         step();
        exp_ifid(32'h0, I0);           drive(1, 1, I0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0);
        check("wrap_ifid_valid", {31'd0, ifid_valid1}, 32'd1);
        check("wrap_ifid_pc", ifid_pc1, 32'hFFFF_FFFC);
        check("wrap_ifid_pc4", ifid_pc4_1, 32'h0);
        check("wrap_ifid_instr", ifid_instr1, I0);
        check("wrap_next_addr", req_addr1, 32'h0);               step();
        step();

        check("req_q_drained", req_q.size(), 32'd0);
        check("ifid_q_drained", ifid_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
